// File: rtl/decoder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decoder_seq_pkg
// Brief    : Shared state encoding for the sequenced step decoder.
// Revision : 1.0
// ============================================================================
package decoder_seq_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/decoder_seq_dec.sv
`default_nettype none
// ============================================================================
// Module   : decoder_seq_dec
// Brief    : Parametrised combinational decoder with enable; the disabled
//            output sits at the inactive level for the selected polarity.
// Revision : 1.0
// ============================================================================
module decoder_seq_dec #(
    parameter int SEL_SIZE = 3,
    parameter int ONE_COLD = 0
) (
    input  logic [SEL_SIZE-1:0]      i_sel,
    input  logic                     i_en,
    output logic [(1<<SEL_SIZE)-1:0] o_y
);

    logic [(1<<SEL_SIZE)-1:0] w_hot;

    for (genvar k = 0; k < (1 << SEL_SIZE); k++) begin : g_line
        assign w_hot[k] = i_en && (i_sel == SEL_SIZE'(k));
    end

    if (ONE_COLD != 0) begin : g_cold
        assign o_y = ~w_hot;
    end else begin : g_hot
        assign o_y = w_hot;
    end

endmodule
`default_nettype wire

// File: rtl/decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : decoder_seq
// Brief    : Sequenced step decoder: registered step counter with start,
//            stall, abort, programmable length and back-to-back restart.
// Revision : 1.0
// ============================================================================
module decoder_seq
    import decoder_seq_pkg::*;
#(
    parameter int SEL_SIZE = 3,
    parameter int ONE_COLD = 0
) (
    input  logic                     iCLK,
    input  logic                     iRSTN,
    input  logic                     iGO,
    input  logic [SEL_SIZE-1:0]      iLEN,
    input  logic                     iHOLD,
    input  logic                     iCLR,
    output logic [SEL_SIZE-1:0]      oSEL,
    output logic [(1<<SEL_SIZE)-1:0] oY,
    output logic                     oBUSY,
    output logic                     oLAST
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_SIZE-1:0] r_sel;
    logic [SEL_SIZE-1:0] w_sel_nxt;
    logic [SEL_SIZE-1:0] r_len;
    logic [SEL_SIZE-1:0] w_len_nxt;
    logic                w_busy;

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_len   <= w_len_nxt;
        end
    end

    // Abort beats stall beats advance; a start is only honoured when idle
    // or on the final step, where it restarts without an idle gap.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_len_nxt   = r_len;
        case (r_state)
            ST_IDLE: begin
                if (iGO) begin
                    w_state_nxt = ST_RUN;
                    w_sel_nxt   = '0;
                    w_len_nxt   = iLEN;
                end
            end
            ST_RUN: begin
                if (iCLR) begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = '0;
                end else if (iHOLD) begin
                    w_sel_nxt   = r_sel;
                end else if (r_sel != r_len) begin
                    w_sel_nxt   = r_sel + SEL_SIZE'(1);
                end else if (iGO) begin
                    w_sel_nxt   = '0;
                    w_len_nxt   = iLEN;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = '0;
            end
        endcase
    end

    assign w_busy = (r_state == ST_RUN);
    assign oBUSY  = w_busy;
    assign oSEL   = r_sel;
    assign oLAST  = w_busy && (r_sel == r_len);

    decoder_seq_dec #(
        .SEL_SIZE (SEL_SIZE),
        .ONE_COLD (ONE_COLD)
    ) u_dec (
        .i_sel (r_sel),
        .i_en  (w_busy),
        .o_y   (oY)
    );

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_seq
// Brief    : Scoreboard bench driving hot and cold instances with one stimulus.
// Revision : 1.0
// ============================================================================
module tb_decoder_seq;

    typedef struct {
        logic       busy;
        logic [2:0] sel;
        logic       last;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       go;
    logic [2:0] len;
    logic       hold;
    logic       clr;

    logic [2:0] sel_h, sel_c;
    logic [7:0] y_h, y_c;
    logic       busy_h, busy_c, last_h, last_c;

    exp_t q[$];
    int   n_vec;
    int   n_err;

    decoder_seq #(.SEL_SIZE(3), .ONE_COLD(0)) u_hot (
        .iCLK(clk), .iRSTN(rst_n), .iGO(go), .iLEN(len), .iHOLD(hold), .iCLR(clr),
        .oSEL(sel_h), .oY(y_h), .oBUSY(busy_h), .oLAST(last_h)
    );

    decoder_seq #(.SEL_SIZE(3), .ONE_COLD(1)) u_cold (
        .iCLK(clk), .iRSTN(rst_n), .iGO(go), .iLEN(len), .iHOLD(hold), .iCLR(clr),
        .oSEL(sel_c), .oY(y_c), .oBUSY(busy_c), .oLAST(last_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input exp_t e);
        logic [7:0] yh;
        yh = e.busy ? (8'h01 << e.sel) : 8'h00;
        chk("busy_hot",  {31'd0, busy_h}, {31'd0, e.busy});
        chk("busy_cold", {31'd0, busy_c}, {31'd0, e.busy});
        chk("sel_hot",   {29'd0, sel_h},  {29'd0, e.sel});
        chk("sel_cold",  {29'd0, sel_c},  {29'd0, e.sel});
        chk("last_hot",  {31'd0, last_h}, {31'd0, e.last});
        chk("last_cold", {31'd0, last_c}, {31'd0, e.last});
        chk("y_hot",     {24'd0, y_h},    {24'd0, yh});
        chk("y_cold",    {24'd0, y_c},    {24'd0, ~yh});
        chk("ones_hot",  32'($countones(y_h)),  e.busy ? 32'd1 : 32'd0);
        chk("ones_cold", 32'($countones(~y_c)), e.busy ? 32'd1 : 32'd0);
    endtask

    // Each queued entry is the state expected after the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_all(e);
            end
        end
    end

    task automatic step(input logic g, input logic [2:0] l, input logic h, input logic c,
                        input logic eb, input logic [2:0] es, input logic el);
        exp_t e;
        @(negedge clk);
        go   = g;
        len  = l;
        hold = h;
        clr  = c;
        e.busy = eb;
        e.sel  = es;
        e.last = el;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t r;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        go    = 1'b0;
        len   = 3'd0;
        hold  = 1'b0;
        clr   = 1'b0;
        r.busy = 1'b0;
        r.sel  = 3'd0;
        r.last = 1'b0;
        #3;
        check_all(r);
        @(negedge clk);
        rst_n = 1'b1;

        // Full range run
        step(1, 3'd7, 0, 0, 1, 3'd0, 0);
        for (int i = 1; i < 7; i++) step(0, 3'd0, 0, 0, 1, 3'(i), 0);
        step(0, 3'd0, 0, 0, 1, 3'd7, 1);
        step(0, 3'd0, 0, 0, 0, 3'd0, 0);
        step(0, 3'd0, 0, 0, 0, 3'd0, 0);

        // Stall at step 2, abort at step 3, hold/clr ignored when idle
        step(1, 3'd4, 0, 0, 1, 3'd0, 0);
        step(0, 3'd4, 0, 0, 1, 3'd1, 0);
        step(0, 3'd4, 0, 0, 1, 3'd2, 0);
        for (int i = 0; i < 3; i++) step(0, 3'd4, 1, 0, 1, 3'd2, 0);
        step(0, 3'd4, 0, 0, 1, 3'd3, 0);
        step(0, 3'd4, 0, 1, 0, 3'd0, 0);
        step(0, 3'd4, 1, 1, 0, 3'd0, 0);

        // Back-to-back with a length change that only lands on restart
        step(1, 3'd2, 0, 0, 1, 3'd0, 0);
        step(1, 3'd1, 0, 0, 1, 3'd1, 0);
        step(1, 3'd1, 0, 0, 1, 3'd2, 1);
        step(1, 3'd1, 0, 0, 1, 3'd0, 0);
        step(1, 3'd1, 0, 0, 1, 3'd1, 1);
        step(0, 3'd1, 0, 0, 0, 3'd0, 0);

        // One-step sequence
        step(1, 3'd0, 0, 0, 1, 3'd0, 1);
        step(0, 3'd0, 0, 0, 0, 3'd0, 0);

        // Hold on the last step delays completion
        step(1, 3'd1, 0, 0, 1, 3'd0, 0);
        step(0, 3'd1, 0, 0, 1, 3'd1, 1);
        step(0, 3'd1, 1, 0, 1, 3'd1, 1);
        step(0, 3'd1, 0, 0, 0, 3'd0, 0);

        // Go on non-last steps ignored; abort wins over restart on last step
        step(1, 3'd3, 0, 0, 1, 3'd0, 0);
        step(1, 3'd0, 0, 0, 1, 3'd1, 0);
        step(1, 3'd0, 0, 0, 1, 3'd2, 0);
        step(0, 3'd0, 0, 0, 1, 3'd3, 1);
        step(1, 3'd5, 0, 1, 0, 3'd0, 0);
        step(0, 3'd0, 0, 0, 0, 3'd0, 0);

        // Asynchronous reset mid-run at step 5
        step(1, 3'd7, 0, 0, 1, 3'd0, 0);
        for (int i = 1; i <= 5; i++) step(0, 3'd0, 0, 0, 1, 3'(i), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all(r);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 3'd0, 0, 0, 0, 3'd0, 0);

        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL queue_drain: got %0d expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
